// File: rtl/tmds_deserializer_1to10.sv
// 1:10 TMDS deserializer fed by a DDR input register at 5x pixel clock,
// with control-token bit-slip word alignment.
module tmds_deserializer_1to10 #(
    parameter int SLIP_WAIT = 16,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 4096
) (
    input  logic       clkx5,
    input  logic       reset,
    input  logic       din_h,
    input  logic       din_l,
    output logic [9:0] dataout,
    output logic       data_valid,
    output logic       locked,
    output logic [3:0] offset,
    output logic       token_det
);
    localparam int MW = $clog2(SLIP_WAIT + 1);
    localparam int TW = $clog2(LOCK_CNT + 1);
    localparam int IW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic [19:0]   sreg_q;
    logic [2:0]    phase_q;
    logic [9:0]    dataout_q;
    logic          data_valid_q;
    logic          token_det_q;
    logic [9:0]    win_d;
    logic          win_tok_d;

    state_t        state_q, state_d;
    logic [MW-1:0] miss_q, miss_d, miss_inc;
    logic [TW-1:0] tok_q, tok_d, tok_inc;
    logic [IW-1:0] idle_q, idle_d, idle_inc;
    logic [3:0]    offset_q, offset_d;
    logic          locked_d;

    // Oldest bits sit at the low end; offset picks the 10-bit window start.
    always_comb begin
        win_d = sreg_q[9:0];
        for (int i = 1; i < 10; i++) begin
            if (offset_q == 4'(i)) begin
                win_d = sreg_q[i +: 10];
            end
        end
    end

    assign win_tok_d = (win_d == 10'h354) || (win_d == 10'h0AB) ||
                       (win_d == 10'h154) || (win_d == 10'h2AB);

    always_ff @(posedge clkx5 or posedge reset) begin
        if (reset) begin
            sreg_q       <= '0;
            phase_q      <= '0;
            dataout_q    <= '0;
            data_valid_q <= 1'b0;
            token_det_q  <= 1'b0;
        end else begin
            sreg_q       <= {din_l, din_h, sreg_q[19:2]};
            phase_q      <= (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
            data_valid_q <= (phase_q == 3'd4);
            if (phase_q == 3'd4) begin
                dataout_q   <= win_d;
                token_det_q <= win_tok_d;
            end
        end
    end

    assign miss_inc = miss_q + MW'(1);
    assign tok_inc  = tok_q + TW'(1);
    assign idle_inc = idle_q + IW'(1);

    always_ff @(posedge clkx5 or posedge reset) begin
        if (reset) begin
            state_q  <= SEARCH;
            miss_q   <= '0;
            tok_q    <= '0;
            idle_q   <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            tok_q    <= tok_d;
            idle_q   <= idle_d;
            offset_q <= offset_d;
        end
    end

    // Each captured word is judged once, in the cycle its strobe is high.
    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        tok_d    = tok_q;
        idle_d   = idle_q;
        offset_d = offset_q;
        if (data_valid_q) begin
            unique case (state_q)
                SEARCH: begin
                    if (token_det_q) begin
                        state_d = CONFIRM;
                        tok_d   = TW'(1);
                        miss_d  = '0;
                    end else if (miss_inc == MW'(SLIP_WAIT)) begin
                        miss_d   = '0;
                        offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                CONFIRM: begin
                    if (token_det_q) begin
                        tok_d = tok_inc;
                        if (tok_inc == TW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            idle_d  = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        miss_d  = '0;
                        tok_d   = '0;
                    end
                end
                LOCKED: begin
                    if (token_det_q) begin
                        idle_d = '0;
                    end else if (idle_inc == IW'(LOSS_CNT)) begin
                        state_d = SEARCH;
                        idle_d  = '0;
                        tok_d   = '0;
                        miss_d  = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        locked_d = (state_q == LOCKED);
    end

    assign dataout    = dataout_q;
    assign data_valid = data_valid_q;
    assign token_det  = token_det_q;
    assign offset     = offset_q;
    assign locked     = locked_d;

endmodule

// File: tb/tb_tmds_deserializer_1to10.sv
// Directed bench for tmds_deserializer_1to10: serial stream queue in,
// recovered word log out, table and sequence checks against hand values.
module tb_tmds_deserializer_1to10;
    logic       clkx5;
    logic       reset;
    logic       din_h;
    logic       din_l;
    logic [9:0] dataout;
    logic       data_valid;
    logic       locked;
    logic [3:0] offset;
    logic       token_det;

    tmds_deserializer_1to10 dut (
        .clkx5      (clkx5),
        .reset      (reset),
        .din_h      (din_h),
        .din_l      (din_l),
        .dataout    (dataout),
        .data_valid (data_valid),
        .locked     (locked),
        .offset     (offset),
        .token_det  (token_det)
    );

    initial clkx5 = 1'b0;
    always #5 clkx5 = ~clkx5;

    typedef struct {
        logic [9:0] w;
        logic       tok;
        logic       lk;
        logic [3:0] off;
        int         cyc;
    } rx_t;

    typedef struct {
        logic [9:0] w;
        logic       tok;
    } vec_t;

    logic tx_q[$];
    rx_t  rx_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    int   first_dv;
    int   last_dv;
    int   gap_bad;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rx_t rxat(input int m);
        rx_t r;
        r = '{w: 'x, tok: 'x, lk: 'x, off: 'x, cyc: -1};
        if (m >= 0 && m < rx_q.size()) r = rx_q[m];
        return r;
    endfunction

    task automatic push_word(input logic [9:0] w, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 10; i++) tx_q.push_back(w[i]);
    endtask

    task automatic push_bits(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(1'b0);
    endtask

    task automatic drive();
        din_h = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b0;
        din_l = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b0;
    endtask

    task automatic step();
        @(negedge clkx5);
        cyc++;
        if (data_valid === 1'b1) begin
            rx_q.push_back('{w: dataout, tok: token_det, lk: locked,
                             off: offset, cyc: cyc});
            if (last_dv >= 0 && cyc - last_dv != 5) gap_bad++;
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
        end
        drive();
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        din_h = 1'b0;
        din_l = 1'b0;
        tx_q.delete();
        rx_q.delete();
        repeat (2) @(negedge clkx5);
    endtask

    task automatic release_reset();
        @(negedge clkx5);
        reset    = 1'b0;
        cyc      = 0;
        first_dv = -1;
        last_dv  = -1;
        gap_bad  = 0;
        drive();
    endtask

    task automatic run_out();
        int guard;
        guard = 0;
        while (tx_q.size() > 0 && guard < 60000) begin
            step();
            guard++;
        end
        repeat (20) step();
    endtask

    vec_t tbl[9];
    int   lat0;
    int   bad;
    int   dv_in_rst;

    initial begin
        tbl[0] = '{10'h354, 1'b1};
        tbl[1] = '{10'h1F0, 1'b0};
        tbl[2] = '{10'h0AB, 1'b1};
        tbl[3] = '{10'h154, 1'b1};
        tbl[4] = '{10'h3FF, 1'b0};
        tbl[5] = '{10'h2AB, 1'b1};
        tbl[6] = '{10'h355, 1'b0};
        tbl[7] = '{10'h0AA, 1'b0};
        tbl[8] = '{10'h153, 1'b0};

        reset = 1'b1;
        din_h = 1'b0;
        din_l = 1'b0;
        #2;
        chk("rst_dataout", 32'(dataout), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_offset", 32'(offset), 0);
        chk("rst_token", 32'(token_det), 0);

        // table: mixed tokens and data words, aligned, never locking
        hold_reset();
        push_bits(8);
        foreach (tbl[j]) push_word(tbl[j].w, 1);
        release_reset();
        run_out();
        chk("first_dv_cycle", 32'(first_dv), 5);
        chk("dv_spacing", 32'(gap_bad), 0);
        chk("startup_word", 32'(rxat(0).w), 0);
        foreach (tbl[j]) begin
            chk("tbl_word", 32'(rxat(j + 2).w), 32'(tbl[j].w));
            chk("tbl_token", 32'(rxat(j + 2).tok), 32'(tbl[j].tok));
        end
        chk("tbl_confirm_drop_locked", 32'(rxat(5).lk), 0);
        chk("tbl_offset", 32'(offset), 0);
        chk("tbl_locked", 32'(locked), 0);

        // aligned lock on repeated 354, latency constant
        hold_reset();
        push_bits(8);
        push_word(10'h354, 8);
        release_reset();
        run_out();
        chk("al_lk_before", 32'(rxat(5).lk), 0);
        chk("al_lk_after", 32'(rxat(6).lk), 1);
        chk("al_offset", 32'(rxat(9).off), 0);
        lat0 = rxat(2).cyc - (8 + 9) / 2;
        chk("al_latency", 32'(lat0), 7);
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            if (rxat(j + 2).w !== 10'h354) bad++;
            if (rxat(j + 2).cyc - (8 + 10 * j + 9) / 2 != lat0) bad++;
        end
        chk("al_words_latency", 32'(bad), 0);

        // skew 3: three slips spaced by 16 words, then lock at offset 3
        hold_reset();
        push_bits(11);
        push_word(10'h354, 56);
        release_reset();
        run_out();
        chk("sk3_off_15", 32'(rxat(15).off), 0);
        chk("sk3_off_16", 32'(rxat(16).off), 1);
        chk("sk3_off_31", 32'(rxat(31).off), 1);
        chk("sk3_off_32", 32'(rxat(32).off), 2);
        chk("sk3_off_48", 32'(rxat(48).off), 3);
        chk("sk3_lk_51", 32'(rxat(51).lk), 0);
        chk("sk3_lk_52", 32'(rxat(52).lk), 1);
        chk("sk3_word", 32'(rxat(55).w), 32'h354);
        chk("sk3_dv_spacing", 32'(gap_bad), 0);

        // skew 9: slips up to 9, no further, lock there
        hold_reset();
        push_bits(17);
        push_word(10'h354, 152);
        release_reset();
        run_out();
        chk("sk9_off_143", 32'(rxat(143).off), 8);
        chk("sk9_off_144", 32'(rxat(144).off), 9);
        chk("sk9_lk_147", 32'(rxat(147).lk), 0);
        chk("sk9_lk_148", 32'(rxat(148).lk), 1);
        chk("sk9_off_final", 32'(offset), 9);
        chk("sk9_word", 32'(rxat(150).w), 32'h354);

        // no tokens: offset wraps 9 -> 0
        hold_reset();
        push_bits(1700);
        release_reset();
        run_out();
        chk("wrap_off_159", 32'(rxat(159).off), 9);
        chk("wrap_off_160", 32'(rxat(160).off), 0);
        chk("wrap_locked", 32'(rxat(160).lk), 0);

        // loss of lock: 4095 idles held, 4096 idles drop
        hold_reset();
        push_bits(8);
        push_word(10'h354, 6);
        push_word(10'h1F0, 4095);
        push_word(10'h354, 1);
        push_word(10'h1F0, 4098);
        release_reset();
        run_out();
        bad = 0;
        for (int m = 6; m <= 4105; m++)
            if (rxat(m).lk !== 1'b1) bad++;
        chk("loss_4095_held", 32'(bad), 0);
        chk("loss_lk_8199", 32'(rxat(8199).lk), 1);
        chk("loss_lk_8200", 32'(rxat(8200).lk), 0);
        chk("loss_off", 32'(rxat(8200).off), 0);

        // reset mid-word while locked, then relock
        hold_reset();
        push_bits(8);
        push_word(10'h354, 8);
        release_reset();
        repeat (47) step();
        chk("mid_pre_locked", 32'(locked), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_dataout", 32'(dataout), 0);
        chk("mid_valid", 32'(data_valid), 0);
        chk("mid_locked", 32'(locked), 0);
        chk("mid_offset", 32'(offset), 0);
        chk("mid_token", 32'(token_det), 0);
        dv_in_rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clkx5);
            if (data_valid !== 1'b0 || locked !== 1'b0) dv_in_rst++;
        end
        chk("mid_quiet", 32'(dv_in_rst), 0);
        tx_q.delete();
        rx_q.delete();
        push_bits(8);
        push_word(10'h354, 8);
        release_reset();
        run_out();
        chk("re_first_dv", 32'(first_dv), 5);
        chk("re_first_word", 32'(rxat(0).w), 0);
        chk("re_lk_5", 32'(rxat(5).lk), 0);
        chk("re_lk_6", 32'(rxat(6).lk), 1);
        chk("re_off", 32'(rxat(6).off), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
